perm_serializer16: RTL and testbench
====================================

// Module: perm_serializer16
// PURPOSE
//  Consumes a 64-bit permutation vector (16 nibble indices) from the permutation/rotate mapper stage.
//  Streams the indices one nibble per beat, element 0 first, over a valid/ready handshake.
//  Checks each accepted vector is a true permutation of 0..N-1 and flags violations.
//  A one-deep pending buffer lets the next vector load while the current one streams.
// PARAMETERS
//  N         16  elements per vector (power of two, >=2)
//  W         4   bits per element, = log2(N)
//  CHECK_EN  1   1: permutation check active; 0: out_bad and perm_err tied 0
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-low
//  in_valid   in   1      in_data valid
//  in_ready   out  1      pending buffer empty; vector accepted when in_valid&&in_ready
//  in_data    in   N*W    element i at bits [W*i+W-1:W*i]
//  out_valid  out  1      out_data valid
//  out_ready  in   1      consumer accepts beat when out_valid&&out_ready
//  out_data   out  W      current element value
//  out_idx    out  W      position of current element in its vector (0..N-1)
//  out_last   out  1      high on the out_idx==N-1 beat
//  out_bad    out  1      current vector failed the permutation check (constant over its N beats)
//  perm_err   out  1      sticky: any accepted vector failed the check
//  vec_cnt    out  16     vectors fully emitted (last beat accepted), wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset (rst low, async): pending empty, state IDLE; out_valid=0, out_data=0, out_idx=0,
//   out_last=0, out_bad=0, perm_err=0, vec_cnt=0; in_ready=1 (comb. = !pend_full).
//  Storage: pend_reg (N*W + bad bit + full flag), shift_reg (N*W), idx counter (W bits), bad_reg.
//  Check at acceptance: build N-bit occupancy mask from in_data; bad = (mask != all ones).
//   Result stored with the vector in pend_reg.
//  FSM: IDLE, STREAM.
//   IDLE: if pend_full -> move pend to shift_reg, idx=0, bad_reg=pend bad, clear pend, -> STREAM.
//   STREAM: out_valid=1; out_data=shift_reg[W-1:0]; on beat accept shift right by W, idx+1.
//    Last beat accepted: vec_cnt+1; if pend_full (or being filled this cycle is NOT allowed:
//    pend loads only from registered state) -> load pend directly, stay STREAM, idx=0 (no bubble);
//    else -> IDLE, out_valid=0 next cycle.
//  Latency: vector accepted at edge t while IDLE -> first beat out_valid at t+2 (pend then shift).
//  Throughput: with in_valid and out_ready held high, N beats per vector, zero idle cycles between vectors.
//  in_ready deasserts the cycle after acceptance while pend full; reasserts the cycle after pend drains.
//  Stall: while out_valid&&!out_ready, out_data/out_idx/out_last/out_bad hold stable.
//  Simultaneous accept into pend and drain of pend in same cycle cannot occur (in_ready=!pend_full).
//  perm_err set on the edge a bad vector is accepted; cleared only by reset.
//  Bad vectors are still streamed unmodified, out_bad=1 on every beat.
//  Reset mid-stream: all state dropped; pending and partially emitted vectors lost, vec_cnt=0.
// TESTING
//  1 Identity 64'hFEDCBA9876543210, out_ready=1 -> out_data 0..15, out_idx 0..15, out_last at beat 15,
//    out_bad=0, vec_cnt=1, first beat 2 cycles after accept.
//  2 Mapped vector 64'h293AC60F47DE581B -> beats B,1,8,5,E,D,7,4,F,0,6,C,A,3,9,2; out_bad=0, perm_err=0.
//  3 Non-permutation 64'h0 -> 16 beats of 0, out_bad=1 on all; perm_err=1 and stays 1 after later good vectors.
//  4 Back-to-back: identity then 64'h293AC60F47DE581B, in_valid held, out_ready=1 -> 32 contiguous beats,
//    out_idx wraps 15->0 without gap, in_ready low from accept+1 until pend drains, vec_cnt=2.
//  5 Backpressure: out_ready random 50% -> data/idx/last stable while stalled, order unchanged, no loss/dup.
//  6 rst low for 1 cycle at out_idx=7 -> outputs 0 immediately (async), in_ready=1; next vector starts at idx 0.

Source files
------------

// File: rtl/perm_serializer16_if.sv
// perm_serializer16_if: vector input, beat output and status signals of the permutation serializer.
interface perm_serializer16_if #(parameter int N = 16, parameter int W = 4);
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [W-1:0]   out_idx;
  logic           out_last;
  logic           out_bad;
  logic           perm_err;
  logic [15:0]    vec_cnt;
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, out_bad, perm_err, vec_cnt
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, out_bad, perm_err, vec_cnt
  );
endinterface

// File: rtl/perm_serializer16.sv
// perm_serializer16: checks 16-nibble permutation vectors and streams them one element per beat,
// with a one-deep pending buffer so the next vector loads while the current one streams.
module perm_serializer16 #(
  parameter int N        = 16,
  parameter int W        = 4,
  parameter bit CHECK_EN = 1'b1
) (
  input logic               clk,
  input logic               rst,
  perm_serializer16_if.slave bus
);
  typedef enum logic {IDLE, STREAM} state_t;
  localparam logic [W-1:0] LAST = W'(N - 1);
  state_t         r_state;
  logic [N*W-1:0] r_pend_data;
  logic           r_pend_bad;
  logic           r_pend_full;
  logic [N*W-1:0] r_shift;
  logic [W-1:0]   r_idx;
  logic           r_bad;
  logic           r_perm_err;
  logic [15:0]    r_vec_cnt;
  logic [N-1:0]   w_mask;
  logic           w_bad;
  logic           w_accept;
  logic           w_beat;
  logic           w_load;
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) w_mask[bus.in_data[W*i +: W]] = 1'b1;
  end
  assign w_bad    = CHECK_EN && !(&w_mask);
  assign w_accept = bus.in_valid && !r_pend_full;
  assign w_beat   = (r_state == STREAM) && bus.out_ready;
  // the pending vector takes over directly on the last beat, so vectors stream without a bubble
  assign w_load   = r_pend_full && (r_state == IDLE || (w_beat && r_idx == LAST));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_pend_data <= '0;
      r_pend_bad  <= 1'b0;
      r_pend_full <= 1'b0;
      r_shift     <= '0;
      r_idx       <= '0;
      r_bad       <= 1'b0;
      r_perm_err  <= 1'b0;
      r_vec_cnt   <= '0;
    end else begin
      if (w_load) begin
        r_shift     <= r_pend_data;
        r_idx       <= '0;
        r_bad       <= r_pend_bad;
        r_pend_full <= 1'b0;
        r_state     <= STREAM;
      end else if (w_beat) begin
        r_shift <= r_shift >> W;
        r_idx   <= r_idx + 1'b1;
        r_state <= (r_idx == LAST) ? IDLE : STREAM;
      end
      if (w_beat && r_idx == LAST) r_vec_cnt <= r_vec_cnt + 16'd1;
      if (w_accept) begin
        r_pend_data <= bus.in_data;
        r_pend_bad  <= w_bad;
        r_pend_full <= 1'b1;
        r_perm_err  <= r_perm_err | w_bad;
      end
    end
  end
  assign bus.in_ready  = !r_pend_full;
  assign bus.out_valid = (r_state == STREAM);
  assign bus.out_data  = r_shift[W-1:0];
  assign bus.out_idx   = r_idx;
  assign bus.out_last  = (r_state == STREAM) && (r_idx == LAST);
  assign bus.out_bad   = r_bad;
  assign bus.perm_err  = r_perm_err;
  assign bus.vec_cnt   = r_vec_cnt;
endmodule

// File: tb/tb_perm_serializer16.sv
// tb_perm_serializer16: directed and random vectors checked against a queue-based model of the expected beats.
module tb_perm_serializer16;
  localparam logic [63:0] ID  = 64'hFEDCBA9876543210;
  localparam logic [63:0] MAP = 64'h293AC60F47DE581B;
  typedef struct {logic [3:0] d; logic [3:0] i; logic l; logic b;} beat_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int fails  = 0;
  beat_t q[$];
  logic [15:0] exp_cnt = '0;
  logic exp_err = 1'b0;
  perm_serializer16_if #(.N(16), .W(4)) b();
  perm_serializer16 #(.N(16), .W(4), .CHECK_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask
  function automatic bit is_bad(input logic [63:0] v);
    int cnt[16];
    foreach (cnt[k]) cnt[k] = 0;
    for (int i = 0; i < 16; i++) cnt[int'(v[4*i +: 4])]++;
    foreach (cnt[k]) if (cnt[k] != 1) return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic [63:0] gen_perm();
    int a[16];
    logic [63:0] v;
    foreach (a[k]) a[k] = k;
    for (int i = 15; i > 0; i--) begin
      int j = int'($urandom_range(i, 0));
      int t = a[i];
      a[i] = a[j];
      a[j] = t;
    end
    for (int i = 0; i < 16; i++) v[4*i +: 4] = 4'(a[i]);
    return v;
  endfunction
  task automatic push_vec(input logic [63:0] v);
    bit bad = is_bad(v);
    for (int i = 0; i < 16; i++) q.push_back('{v[4*i +: 4], 4'(i), i == 15, bad});
    if (bad) exp_err = 1'b1;
  endtask
  // one clock: compare visible beat, advance, then update the model with what was handshaken
  task automatic tick();
    bit beat = b.out_valid && b.out_ready;
    bit acc  = b.in_valid && b.in_ready;
    logic [63:0] v = b.in_data;
    if (q.size() == 0) chk("idle_valid", 64'(b.out_valid), 64'd0);
    else if (b.out_valid) begin
      chk("out_data", 64'(b.out_data), 64'(q[0].d));
      chk("out_idx",  64'(b.out_idx),  64'(q[0].i));
      chk("out_last", 64'(b.out_last), 64'(q[0].l));
      chk("out_bad",  64'(b.out_bad),  64'(q[0].b));
    end
    @(posedge clk);
    @(negedge clk);
    if (beat && q.size() > 0) begin
      if (q[0].l) exp_cnt = exp_cnt + 16'd1;
      void'(q.pop_front());
    end
    if (acc) push_vec(v);
    chk("perm_err", 64'(b.perm_err), 64'(exp_err));
    chk("vec_cnt",  64'(b.vec_cnt),  64'(exp_cnt));
  endtask
  task automatic drain(input bit contig);
    int n = 0;
    b.out_ready = 1'b1;
    while (q.size() > 0 && n < 400) begin
      if (contig) chk("no_gap", 64'(b.out_valid), 64'd1);
      tick();
      n++;
    end
    chk("drain_done", 64'(q.size()), 64'd0);
  endtask
  initial begin
    int n;
    b.in_valid = 1'b0;
    b.in_data = '0;
    b.out_ready = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(b.out_valid), 64'd0);
    chk("rst_data",  64'(b.out_data),  64'd0);
    chk("rst_idx",   64'(b.out_idx),   64'd0);
    chk("rst_last",  64'(b.out_last),  64'd0);
    chk("rst_bad",   64'(b.out_bad),   64'd0);
    chk("rst_err",   64'(b.perm_err),  64'd0);
    chk("rst_cnt",   64'(b.vec_cnt),   64'd0);
    chk("rst_ready", 64'(b.in_ready),  64'd1);
    rst = 1'b1;
    @(negedge clk);
    // identity vector with latency check
    b.in_data = ID;
    b.in_valid = 1'b1;
    b.out_ready = 1'b1;
    tick();
    b.in_valid = 1'b0;
    chk("lat_t1_valid", 64'(b.out_valid), 64'd0);
    tick();
    chk("lat_t2_valid", 64'(b.out_valid), 64'd1);
    drain(1'b1);
    chk("id_cnt", 64'(b.vec_cnt), 64'd1);
    // mapped vector
    b.in_data = MAP;
    b.in_valid = 1'b1;
    tick();
    b.in_valid = 1'b0;
    drain(1'b0);
    chk("map_err", 64'(b.perm_err), 64'd0);
    // non-permutation
    b.in_data = 64'h0;
    b.in_valid = 1'b1;
    tick();
    b.in_valid = 1'b0;
    drain(1'b0);
    chk("zero_err", 64'(b.perm_err), 64'd1);
    // back-to-back
    b.in_data = ID;
    b.in_valid = 1'b1;
    tick();
    chk("b2b_ready_low", 64'(b.in_ready), 64'd0);
    b.in_data = MAP;
    tick();
    chk("b2b_ready_high", 64'(b.in_ready), 64'd1);
    tick();
    b.in_valid = 1'b0;
    chk("b2b_ready_pend", 64'(b.in_ready), 64'd0);
    drain(1'b1);
    chk("b2b_ready_end", 64'(b.in_ready), 64'd1);
    chk("b2b_err_sticky", 64'(b.perm_err), 64'd1);
    // random traffic with backpressure
    for (int k = 0; k < 400; k++) begin
      b.out_ready = 1'($urandom % 2);
      b.in_valid = ($urandom % 3) == 0;
      b.in_data = ($urandom % 4 == 0) ? {$urandom, $urandom} : gen_perm();
      tick();
    end
    b.in_valid = 1'b0;
    drain(1'b0);
    // asynchronous reset mid-stream
    b.in_data = ID;
    b.in_valid = 1'b1;
    tick();
    b.in_valid = 1'b0;
    n = 0;
    while (!(b.out_valid && b.out_idx == 4'd7) && n < 100) begin
      tick();
      n++;
    end
    chk("reach_idx7", 64'(b.out_idx), 64'd7);
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(b.out_valid), 64'd0);
    chk("arst_data",  64'(b.out_data),  64'd0);
    chk("arst_idx",   64'(b.out_idx),   64'd0);
    chk("arst_err",   64'(b.perm_err),  64'd0);
    chk("arst_cnt",   64'(b.vec_cnt),   64'd0);
    chk("arst_ready", 64'(b.in_ready),  64'd1);
    q.delete();
    exp_cnt = '0;
    exp_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    b.in_data = MAP;
    b.in_valid = 1'b1;
    tick();
    b.in_valid = 1'b0;
    drain(1'b0);
    chk("post_rst_cnt", 64'(b.vec_cnt), 64'd1);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
